// File: rtl/runtime_ctr_bank.sv
// Multi-channel start/stop cycle counter bank with sticky overflow flags and
// a coherent snapshot (shadow) register set for host readout.
module runtime_ctr_bank #(
  parameter int NUM_CH    = 4,
  parameter int CTR_WIDTH = 32,
  parameter bit SATURATE  = 1'b0,
  parameter bit ACCUM     = 1'b0,
  parameter int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             ch_start,
  input  logic [NUM_CH-1:0]             ch_stop,
  input  logic                          clear,
  input  logic                          snap,
  input  logic [SEL_W-1:0]              rd_sel,
  output logic [CTR_WIDTH-1:0]          rd_data,
  output logic [NUM_CH*CTR_WIDTH-1:0]   ctr_val,
  output logic [NUM_CH-1:0]             running,
  output logic [NUM_CH-1:0]             ovf,
  output logic                          snap_valid
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CTR_WIDTH-1:0] CTR_ZERO = {CTR_WIDTH{1'b0}};
  localparam logic [CTR_WIDTH-1:0] CTR_ONES = {CTR_WIDTH{1'b1}};
  localparam logic [CTR_WIDTH-1:0] CTR_ONE  = {{(CTR_WIDTH-1){1'b0}}, 1'b1};

  logic [CTR_WIDTH-1:0] count_r     [NUM_CH];
  logic [CTR_WIDTH-1:0] shadow_r    [NUM_CH];
  logic [0:0]           state_r     [NUM_CH];
  logic [NUM_CH-1:0]    ovf_r;
  logic                 snap_valid_r;

  logic [CTR_WIDTH-1:0] base_s      [NUM_CH];
  logic [CTR_WIDTH-1:0] count_nxt_s [NUM_CH];
  logic [0:0]           state_nxt_s [NUM_CH];
  logic [NUM_CH-1:0]    ovf_nxt_s;

  // An increment past all-ones either wraps or pins, depending on SATURATE.
  function automatic logic [CTR_WIDTH-1:0] bump(input logic [CTR_WIDTH-1:0] v);
    if (&v) begin
      return SATURATE ? CTR_ONES : CTR_ZERO;
    end else begin
      return v + CTR_ONE;
    end
  endfunction

  // Per-channel IDLE/RUN next-state, next-count and overflow logic
  always_comb begin
    ovf_nxt_s = ovf_r;
    for (int i = 0; i < NUM_CH; i++) begin
      base_s[i]      = ACCUM ? count_r[i] : CTR_ZERO;
      count_nxt_s[i] = count_r[i];
      state_nxt_s[i] = state_r[i];
      case (state_r[i])
        ST_IDLE: begin
          if (ch_start[i]) begin
            // A fresh run (ACCUM=0) starts from zero and drops any old overflow.
            count_nxt_s[i] = bump(base_s[i]);
            ovf_nxt_s[i]   = (ACCUM ? ovf_r[i] : 1'b0) | (&base_s[i]);
            state_nxt_s[i] = ch_stop[i] ? ST_IDLE : ST_RUN;
          end else begin
            count_nxt_s[i] = count_r[i];
          end
        end
        ST_RUN: begin
          count_nxt_s[i] = bump(count_r[i]);
          ovf_nxt_s[i]   = ovf_r[i] | (&count_r[i]);
          state_nxt_s[i] = ch_stop[i] ? ST_IDLE : ST_RUN;
        end
        default: begin
          state_nxt_s[i] = ST_IDLE;
        end
      endcase
    end
  end

  // State, count, overflow and snapshot registers; clear outranks all events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_r[i]  <= CTR_ZERO;
        shadow_r[i] <= CTR_ZERO;
        state_r[i]  <= ST_IDLE;
      end
      ovf_r        <= {NUM_CH{1'b0}};
      snap_valid_r <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_r[i]  <= CTR_ZERO;
        shadow_r[i] <= CTR_ZERO;
        state_r[i]  <= ST_IDLE;
      end
      ovf_r        <= {NUM_CH{1'b0}};
      snap_valid_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_r[i] <= count_nxt_s[i];
        state_r[i] <= state_nxt_s[i];
        if (snap) begin
          shadow_r[i] <= count_r[i];
        end else begin
          shadow_r[i] <= shadow_r[i];
        end
      end
      ovf_r        <= ovf_nxt_s;
      snap_valid_r <= snap_valid_r | snap;
    end
  end

  // Shadow readout; out-of-range selects read as zero
  always_comb begin
    rd_data = CTR_ZERO;
    if (int'(rd_sel) < NUM_CH) begin
      rd_data = shadow_r[rd_sel];
    end else begin
      rd_data = CTR_ZERO;
    end
  end

  // Flatten live counts and per-channel run flags onto the output buses
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ctr_val[i*CTR_WIDTH +: CTR_WIDTH] = count_r[i];
      running[i]                        = (state_r[i] == ST_RUN);
    end
  end

  assign ovf        = ovf_r;
  assign snap_valid = snap_valid_r;

endmodule

// File: tb/tb_runtime_ctr_bank.sv
// Directed bench for runtime_ctr_bank: a single-cycle vector table on the default
// configuration plus sequences for long runs, accumulation, overflow, snapshot and reset.
module tb_runtime_ctr_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  start = 4'd0;
  logic [3:0]  stop = 4'd0;
  logic        clear = 1'b0;
  logic        snap = 1'b0;
  logic [1:0]  rd_sel = 2'd0;

  logic [127:0] m_ctr;  logic [3:0] m_run, m_ovf; logic [31:0] m_rd; logic m_sv;
  logic [95:0]  a_ctr;  logic [2:0] a_run, a_ovf; logic [31:0] a_rd; logic a_sv;
  logic [15:0]  w_ctr;  logic [3:0] w_run, w_ovf; logic [3:0]  w_rd; logic w_sv;
  logic [15:0]  s_ctr;  logic [3:0] s_run, s_ovf; logic [3:0]  s_rd; logic s_sv;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Default configuration: 4 x 32 bit, wrap, fresh runs.
  runtime_ctr_bank #(.NUM_CH(4), .CTR_WIDTH(32), .SATURATE(1'b0), .ACCUM(1'b0)) u_m (
    .clk(clk), .rst(rst), .ch_start(start), .ch_stop(stop), .clear(clear), .snap(snap),
    .rd_sel(rd_sel), .rd_data(m_rd), .ctr_val(m_ctr), .running(m_run), .ovf(m_ovf),
    .snap_valid(m_sv));

  // Accumulating, 3 channels so that rd_sel=3 is out of range.
  runtime_ctr_bank #(.NUM_CH(3), .CTR_WIDTH(32), .SATURATE(1'b0), .ACCUM(1'b1)) u_a (
    .clk(clk), .rst(rst), .ch_start(start[2:0]), .ch_stop(stop[2:0]), .clear(clear),
    .snap(snap), .rd_sel(rd_sel), .rd_data(a_rd), .ctr_val(a_ctr), .running(a_run),
    .ovf(a_ovf), .snap_valid(a_sv));

  runtime_ctr_bank #(.NUM_CH(4), .CTR_WIDTH(4), .SATURATE(1'b0), .ACCUM(1'b0)) u_w (
    .clk(clk), .rst(rst), .ch_start(start), .ch_stop(stop), .clear(clear), .snap(snap),
    .rd_sel(rd_sel), .rd_data(w_rd), .ctr_val(w_ctr), .running(w_run), .ovf(w_ovf),
    .snap_valid(w_sv));

  runtime_ctr_bank #(.NUM_CH(4), .CTR_WIDTH(4), .SATURATE(1'b1), .ACCUM(1'b0)) u_s (
    .clk(clk), .rst(rst), .ch_start(start), .ch_stop(stop), .clear(clear), .snap(snap),
    .rd_sel(rd_sel), .rd_data(s_rd), .ctr_val(s_ctr), .running(s_run), .ovf(s_ovf),
    .snap_valid(s_sv));

  typedef struct {
    logic [3:0]  st;
    logic [3:0]  sp;
    logic        clr;
    logic        snp;
    logic [1:0]  sel;
    logic [31:0] e_c0;
    logic [31:0] e_c3;
    logic [3:0]  e_run;
    logic [3:0]  e_ovf;
    logic [31:0] e_rd;
    logic        e_sv;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [3:0] m);
    start = m;
    cyc(1);
    start = 4'd0;
  endtask

  task automatic pulse_stop(input logic [3:0] m);
    stop = m;
    cyc(1);
    stop = 4'd0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  initial begin
    //         st       sp       clr   snp   sel    c0     c3     run      ovf      rd     sv
    vt[0] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0, 32'd1, 32'd0, 4'b0001, 4'b0000, 32'd0, 1'b0};
    vt[1] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 32'd2, 32'd0, 4'b0001, 4'b0000, 32'd0, 1'b0};
    vt[2] = '{4'b1000, 4'b1000, 1'b0, 1'b0, 2'd0, 32'd3, 32'd1, 4'b0001, 4'b0000, 32'd0, 1'b0};
    vt[3] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0, 32'd4, 32'd1, 4'b0001, 4'b0000, 32'd0, 1'b0};
    vt[4] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 32'd5, 32'd1, 4'b0001, 4'b0000, 32'd4, 1'b1};
    vt[5] = '{4'b0001, 4'b0001, 1'b0, 1'b0, 2'd0, 32'd6, 32'd1, 4'b0000, 4'b0000, 32'd4, 1'b1};
    vt[6] = '{4'b0000, 4'b0001, 1'b0, 1'b0, 2'd0, 32'd6, 32'd1, 4'b0000, 4'b0000, 32'd4, 1'b1};
    vt[7] = '{4'b1000, 4'b0000, 1'b0, 1'b0, 2'd0, 32'd6, 32'd1, 4'b1000, 4'b0000, 32'd4, 1'b1};
    vt[8] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 32'd6, 32'd2, 4'b1000, 4'b0000, 32'd1, 1'b1};
    vt[9] = '{4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 32'd0, 32'd0, 4'b0000, 4'b0000, 32'd0, 1'b0};

    cyc(2);
    chk("reset ctr0", m_ctr[31:0], 32'd0);
    chk("reset ctr any", {31'd0, |m_ctr}, 32'd0);
    chk("reset running", {28'd0, m_run}, 32'd0);
    chk("reset ovf", {28'd0, m_ovf}, 32'd0);
    chk("reset snap_valid", {31'd0, m_sv}, 32'd0);
    rst = 1'b0;
    cyc(1);

    for (int k = 0; k < 10; k++) begin
      start = vt[k].st; stop = vt[k].sp; clear = vt[k].clr; snap = vt[k].snp; rd_sel = vt[k].sel;
      cyc(1);
      chk($sformatf("vec%0d ctr0", k), m_ctr[31:0], vt[k].e_c0);
      chk($sformatf("vec%0d ctr3", k), m_ctr[127:96], vt[k].e_c3);
      chk($sformatf("vec%0d running", k), {28'd0, m_run}, {28'd0, vt[k].e_run});
      chk($sformatf("vec%0d ovf", k), {28'd0, m_ovf}, {28'd0, vt[k].e_ovf});
      chk($sformatf("vec%0d rd_data", k), m_rd, vt[k].e_rd);
      chk($sformatf("vec%0d snap_valid", k), {31'd0, m_sv}, {31'd0, vt[k].e_sv});
    end
    start = 4'd0; stop = 4'd0; clear = 1'b0; snap = 1'b0; rd_sel = 2'd0;

    // Long run with an ignored restart in the middle.
    rst = 1'b1; cyc(2); rst = 1'b0;
    pulse_start(4'b0001); cyc(32);
    pulse_start(4'b0001); cyc(32);
    pulse_stop(4'b0001);
    chk("long ctr0", m_ctr[31:0], 32'd67);
    chk("long running0", {31'd0, m_run[0]}, 32'd0);
    chk("long others", m_ctr[63:32] | m_ctr[95:64] | m_ctr[127:96], 32'd0);

    // Two runs of 10 and 5 cycles on ch1, fresh vs accumulating.
    do_clear();
    pulse_start(4'b0010); cyc(8); pulse_stop(4'b0010);
    chk("run10 fresh", m_ctr[63:32], 32'd10);
    chk("run10 accum", a_ctr[63:32], 32'd10);
    pulse_start(4'b0010); cyc(3); pulse_stop(4'b0010);
    chk("run5 fresh", m_ctr[63:32], 32'd5);
    chk("run5 accum", a_ctr[63:32], 32'd15);
    chk("run5 accum idle", {31'd0, a_run[1]}, 32'd0);

    // 4-bit counters running 16 cycles: wrap vs saturate.
    do_clear();
    pulse_start(4'b0100); cyc(14);
    chk("w pre-ovf ctr2", {28'd0, w_ctr[11:8]}, 32'd15);
    chk("w pre-ovf flag", {31'd0, w_ovf[2]}, 32'd0);
    cyc(1);
    chk("wrap ctr2", {28'd0, w_ctr[11:8]}, 32'd0);
    chk("wrap ovf2", {31'd0, w_ovf[2]}, 32'd1);
    chk("sat ctr2", {28'd0, s_ctr[11:8]}, 32'd15);
    chk("sat ovf2", {31'd0, s_ovf[2]}, 32'd1);
    cyc(5);
    chk("wrap ctr2 later", {28'd0, w_ctr[11:8]}, 32'd5);
    chk("wrap ovf2 sticky", {31'd0, w_ovf[2]}, 32'd1);
    chk("sat ctr2 held", {28'd0, s_ctr[11:8]}, 32'd15);
    pulse_stop(4'b0100);
    pulse_start(4'b0100);
    chk("fresh ctr2", {28'd0, w_ctr[11:8]}, 32'd1);
    chk("fresh ovf2 cleared", {31'd0, w_ovf[2]}, 32'd0);

    // Snapshot while ch0 keeps counting.
    do_clear();
    pulse_start(4'b0001); cyc(19);
    chk("snap pre ctr0", m_ctr[31:0], 32'd20);
    snap = 1'b1; cyc(1); snap = 1'b0;
    rd_sel = 2'd0; #1;
    chk("snap rd0", m_rd, 32'd20);
    chk("snap live ctr0", m_ctr[31:0], 32'd21);
    chk("snap valid", {31'd0, m_sv}, 32'd1);
    chk("snap accum rd0", a_rd, 32'd20);
    cyc(1);
    chk("snap rd0 held", m_rd, 32'd20);
    chk("snap live ctr0 next", m_ctr[31:0], 32'd22);
    rd_sel = 2'd3; #1;
    chk("rd out of range", a_rd, 32'd0);
    rd_sel = 2'd0;

    // Asynchronous reset mid-run.
    do_clear();
    pulse_start(4'b0001); cyc(4);
    snap = 1'b1; cyc(1); snap = 1'b0;
    chk("pre-rst ctr0", m_ctr[31:0], 32'd6);
    #3 rst = 1'b1;
    #1;
    chk("async ctr any", {31'd0, |m_ctr}, 32'd0);
    chk("async running", {28'd0, m_run}, 32'd0);
    chk("async snap_valid", {31'd0, m_sv}, 32'd0);
    chk("async rd0", m_rd, 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(5);
    chk("post-rst ctr0", m_ctr[31:0], 32'd0);
    chk("post-rst running", {28'd0, m_run}, 32'd0);
    pulse_start(4'b0001);
    chk("post-rst restart", m_ctr[31:0], 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
